mio_wait_ctrl: RTL

//  Memory/IO bus sequencer between the multi-cycle control FSM and the MIO bus.

---
 rtl/mio_wait_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mio_wait_ctrl.sv
// Memory/IO bus sequencer: one read/write access with minimum wait states and a ready timeout.
// Latency: request seen in IDLE -> earliest done pulse MIN_WAIT+2 cycles later.
// Backpressure: stall holds the controller while a request is pending or in ACCESS; requests are ignored in DONE/ERR.
module mio_wait_ctrl #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MIN_WAIT = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          MIO_ready,
    input  logic [DW-1:0] mio_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          CPU_MIO,
    output logic [DW-1:0] rdata_out,
    output logic          done,
    output logic          timeout,
    output logic          stall,
    output logic [2:0]    state_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERR    = 3'd3
    } state_t;

    // A zero-width counter is not legal, so MAX_WAIT=0 still gets one bit.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic            r_is_wr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;

    logic            w_req;
    logic            w_min_ok;
    logic            w_hit;
    logic            w_last;

    assign w_req  = req_rd | req_wr;
    assign w_last = (r_cnt == MAX_C);
    assign w_hit  = w_min_ok & MIO_ready;

    // With no minimum wait, ready is honoured from the first ACCESS cycle.
    generate
        if (MIN_WAIT == 0) begin : g_no_min
            assign w_min_ok = 1'b1;
        end else begin : g_min
            localparam logic [CW-1:0] MIN_C = CW'(MIN_WAIT);
            assign w_min_ok = (r_cnt >= MIN_C);
        end
    endgenerate

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next state and counter; the counter stops at MAX_WAIT since ACCESS ends there anyway.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_ACCESS;
                    w_next_cnt   = '0;
                end
            end
            ST_ACCESS: begin
                if (w_hit) begin
                    w_next_state = ST_DONE;
                end else if (w_last) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERR:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Latch request on acceptance (write wins when both are raised); capture read data on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_is_wr <= req_wr;
                r_addr  <= addr_in;
                r_wdata <= wdata_in;
            end
            if (r_state == ST_ACCESS && w_hit && !r_is_wr) begin
                r_rdata <= mio_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata_out = r_rdata;
    assign CPU_MIO   = (r_state == ST_ACCESS);
    assign mem_rd    = (r_state == ST_ACCESS) & ~r_is_wr;
    assign mem_wr    = (r_state == ST_ACCESS) &  r_is_wr;
    assign done      = (r_state == ST_DONE);
    assign timeout   = (r_state == ST_ERR);
    // Reset gates the request term so every output reads 0 while reset is held.
    assign stall     = reset & ((r_state == ST_ACCESS) | ((r_state == ST_IDLE) & w_req));
    assign state_out = r_state;

endmodule
